// File: rtl/demux_pkg.sv
// Shared types and helpers for the registered 1-to-16 32-bit demux.
package demux_pkg;

  localparam int SEL_W = 4;
  localparam int N_OUT = 16;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  function automatic logic [N_OUT-1:0] onehot16(
    input logic [SEL_W-1:0] idx
  );
    logic [N_OUT-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decod4pra16.sv
// Combinational 4-to-16 one-hot decoder producing per-entry write enables.
module decod4pra16
  import demux_pkg::*;
(
  input  logic             en_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [N_OUT-1:0] we_o
);

  assign we_o = en_i ? onehot16(sel_i) : '0;

endmodule

// File: rtl/demux16pra32bits_reg.sv
// Registered 1-to-16 demux with valid flags and sequenced clear-all.
// Optional DEMUX_ZERO_LOCK_EN hardwires entry 0 to zero / always valid.
module demux16pra32bits_reg
  import demux_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  controlador,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done,
  output logic [DATA_W-1:0] output0,
  output logic [DATA_W-1:0] output1,
  output logic [DATA_W-1:0] output2,
  output logic [DATA_W-1:0] output3,
  output logic [DATA_W-1:0] output4,
  output logic [DATA_W-1:0] output5,
  output logic [DATA_W-1:0] output6,
  output logic [DATA_W-1:0] output7,
  output logic [DATA_W-1:0] output8,
  output logic [DATA_W-1:0] output9,
  output logic [DATA_W-1:0] output10,
  output logic [DATA_W-1:0] output11,
  output logic [DATA_W-1:0] output12,
  output logic [DATA_W-1:0] output13,
  output logic [DATA_W-1:0] output14,
  output logic [DATA_W-1:0] output15,
  output logic [N_OUT-1:0]  strobe,
  output logic [N_OUT-1:0]  valid_mask
);

  state_e                        state_q, state_d;
  logic [SEL_W-1:0]              cnt_q, cnt_d;
  logic [N_OUT-1:0][DATA_W-1:0]  data_q, data_d;
  logic [N_OUT-1:0]              vmask_q, vmask_d;
  logic [N_OUT-1:0]              strobe_q, strobe_d;
  logic                          done_q, done_d;
  logic                          wr_acc;
  logic                          wr_en;
  logic [N_OUT-1:0]              we;

  assign in_ready = (state_q == IDLE) && !clear_req;
  assign wr_acc   = in_valid && in_ready;

`ifdef DEMUX_ZERO_LOCK_EN
  // Writes to entry 0 are accepted but leave no trace.
  assign wr_en    = wr_acc && (controlador != '0);
`else
  assign wr_en    = wr_acc;
`endif

  decod4pra16 u_dec (
    .en_i  (wr_en),
    .sel_i (controlador),
    .we_o  (we)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    vmask_d  = vmask_q;
    strobe_d = we;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
        for (int i = 0; i < N_OUT; i++) begin
          if (we[i]) begin
            data_d[i]  = data_in;
            vmask_d[i] = 1'b1;
          end
        end
      end
      CLEAR: begin
        data_d[cnt_q]  = '0;
        vmask_d[cnt_q] = 1'b0;
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      vmask_q  <= '0;
      strobe_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      vmask_q  <= vmask_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  assign busy       = (state_q == CLEAR);
  assign clear_done = done_q;
  assign strobe     = strobe_q;

`ifdef DEMUX_ZERO_LOCK_EN
  assign valid_mask = vmask_q | 16'h0001;
`else
  assign valid_mask = vmask_q;
`endif

  assign output0  = data_q[0];
  assign output1  = data_q[1];
  assign output2  = data_q[2];
  assign output3  = data_q[3];
  assign output4  = data_q[4];
  assign output5  = data_q[5];
  assign output6  = data_q[6];
  assign output7  = data_q[7];
  assign output8  = data_q[8];
  assign output9  = data_q[9];
  assign output10 = data_q[10];
  assign output11 = data_q[11];
  assign output12 = data_q[12];
  assign output13 = data_q[13];
  assign output14 = data_q[14];
  assign output15 = data_q[15];

endmodule
